// File: rtl/voq_output_drain.sv
// Per-output-port drain: round-robin over the input VOQs feeding this port,
// reading one whole zero-terminated packet at a time onto a valid/ready stream.
//
// state | meaning
// IDLE  | no packet in flight; arbitrate among VOQs with unread words
// READ  | pulse rden for cur_src once a word is available (parks if starved)
// WAIT  | RAM read latency; capture ram_q into hold
// SEND  | present hold downstream until accepted
module voq_output_drain #(
    parameter int N_IN   = 4,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [N_IN*ADDR_W-1:0]   wr_count,
    output logic [N_IN*ADDR_W-1:0]   ram_rd_add,
    output logic [N_IN-1:0]          ram_rden,
    input  logic [N_IN*DATA_W-1:0]   ram_q,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [1:0]               cur_src,
    output logic [31:0]              pkt_count
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, SEND} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   rd_ptr [N_IN];
    logic [ADDR_W-1:0]   wr_ptr [N_IN];
    logic [DATA_W-1:0]   q_word [N_IN];
    logic [N_IN-1:0]     avail;
    logic [1:0]          rr_ptr;
    logic [1:0]          pick;
    logic [1:0]          scan_idx;
    logic                pick_vld;
    logic                first_word;
    logic [DATA_W-1:0]   hold;
    logic                accept;

    always_comb begin
        ram_rd_add = '0;
        for (int i = 0; i < N_IN; i++) begin
            wr_ptr[i] = wr_count[i*ADDR_W +: ADDR_W];
            q_word[i] = ram_q[i*DATA_W +: DATA_W];
            avail[i]  = (rd_ptr[i] != wr_ptr[i]);
            ram_rd_add[i*ADDR_W +: ADDR_W] = rd_ptr[i];
        end
    end

    // Scan from the far end back so the candidate closest to rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = rr_ptr;
        scan_idx = rr_ptr;
        for (int k = N_IN - 1; k >= 0; k--) begin
            scan_idx = rr_ptr + 2'(k);
            if (avail[scan_idx]) begin
                pick_vld = 1'b1;
                pick     = scan_idx;
            end
        end
    end

    assign accept    = (state == SEND) && out_ready;
    assign out_valid = (state == SEND);
    assign out_data  = hold;
    assign out_sop   = out_valid && first_word;
    assign out_eop   = out_valid && (hold == '0);

    always_comb begin
        state_nxt = state;
        ram_rden  = '0;
        case (state)
            IDLE: if (pick_vld) state_nxt = READ;
            READ: begin
                if (avail[cur_src]) begin
                    ram_rden[cur_src] = reset && !flush;
                    state_nxt         = WAIT;
                end
            end
            WAIT: state_nxt = SEND;
            SEND: if (out_ready) state_nxt = (hold == '0) ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cur_src    <= '0;
            first_word <= 1'b0;
            hold       <= '0;
            for (int i = 0; i < N_IN; i++) rd_ptr[i] <= '0;
            if (!reset) pkt_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_vld) begin
                cur_src    <= pick;
                first_word <= 1'b1;
            end
            if (state == WAIT) hold <= q_word[cur_src];
            if (accept) begin
                rd_ptr[cur_src] <= rd_ptr[cur_src] + 1'b1;
                first_word      <= 1'b0;
                if (hold == '0) begin
                    pkt_count <= pkt_count + 32'd1;
                    rr_ptr    <= cur_src + 2'd1;
                end
            end
        end
    end

endmodule
